// File: rtl/splash_drawer.sv
// splash_drawer: sweeps the full screen once per rising edge of showTitle or
// showGameOver, reading a 1-cycle-latency image ROM and emitting one VGA
// pixel write per cycle. Idle (plot=0, busy=0) between sweeps.
module splash_drawer #(
    parameter int SCR_W    = 160,
    parameter int SCR_H    = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int ADDR_W   = 15,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                showTitle,
    input  logic                showGameOver,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic                rom_sel,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH} state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(SCR_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCR_H - 1);

    state_t         state;
    logic           prev_t, prev_g;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    // Coordinates of the pixel whose ROM read is in flight, plus its valid bit
    logic [X_W-1:0] px;
    logic [Y_W-1:0] py;
    logic           pv;

    logic rise_t, rise_g, start, abort, last;

    // Edge detection and sweep start/restart decisions
    always_comb begin
        rise_t = showTitle & ~prev_t;
        rise_g = showGameOver & ~prev_g;
        // A fresh sweep may begin from IDLE, or straight out of FLUSH so a
        // rise landing on the final cycle is not lost.
        start  = (state != DRAW) & (rise_t | rise_g);
        // Only the other image's flag interrupts a sweep; game-over wins ties.
        abort  = (state == DRAW) &
                 ((~rom_sel & rise_g) | (rom_sel & rise_t & ~rise_g));
        last   = (cx == X_LAST) & (cy == Y_LAST);
    end

    // Sweep FSM, raster counters, fetch/plot pipeline and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            prev_t   <= 1'b0;
            prev_g   <= 1'b0;
            cx       <= '0;
            cy       <= '0;
            px       <= '0;
            py       <= '0;
            pv       <= 1'b0;
            rom_addr <= '0;
            rom_sel  <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            prev_t <= showTitle;
            prev_g <= showGameOver;

            // Plot stage: ROM data now answers the address issued last cycle
            x      <= px;
            y      <= py;
            colour <= rom_data;
            plot   <= pv;
            done   <= (state == FLUSH);

            // Fetch stage: the address on the bus this cycle is latched by the ROM
            pv <= (state == DRAW);
            px <= cx;
            py <= cy;

            case (state)
                IDLE, FLUSH: begin
                    if (start) begin
                        state    <= DRAW;
                        rom_sel  <= rise_g;
                        cx       <= '0;
                        cy       <= '0;
                        rom_addr <= '0;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                DRAW: begin
                    if (abort) begin
                        rom_sel  <= ~rom_sel;
                        cx       <= '0;
                        cy       <= '0;
                        rom_addr <= '0;
                    end else if (last) begin
                        state <= FLUSH;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                        if (cx == X_LAST) begin
                            cx <= '0;
                            cy <= cy + 1'b1;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_splash_drawer.sv
// Bench for splash_drawer: a ROM model, a scoreboard of expected pixels filled
// as each sweep is triggered, and one task per scenario.
module tb_splash_drawer;

    localparam int NPIX = 160 * 120;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        showTitle = 1'b0;
    logic        showGameOver = 1'b0;
    logic [2:0]  rom_data = 3'd0;
    logic [14:0] rom_addr;
    logic        rom_sel;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, done;

    int   checks = 0;
    int   failures = 0;
    int   nplot = 0;
    int   ndone = 0;
    pix_t exp_q[$];

    splash_drawer dut (
        .clk(clk), .rst(rst), .showTitle(showTitle), .showGameOver(showGameOver),
        .rom_data(rom_data), .rom_addr(rom_addr), .rom_sel(rom_sel),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: pixel value is the low address bits, inverted for game-over
    always @(posedge clk) rom_data <= rom_addr[2:0] ^ {3{rom_sel}};

    task automatic push_sweep(input bit sel, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            pix_t p;
            p.x = 8'(i % 160);
            p.y = 7'(i / 160);
            p.c = 3'(i & 7) ^ {3{sel}};
            exp_q.push_back(p);
        end
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk); #1;
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic idle_flags();
        showTitle = 1'b0;
        showGameOver = 1'b0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    // Scoreboard: every plot must match the next expected pixel; done rides with a plot
    task automatic monitor();
        pix_t p;
        forever begin
            @(negedge clk);
            if (plot === 1'b1) begin
                nplot++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pixel_unexpected got x=%0d y=%0d c=%0d want none", x, y, colour);
                end else begin
                    p = exp_q.pop_front();
                    if ({x, y, colour} !== p) begin
                        failures++;
                        $display("FAIL pixel got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                                 x, y, colour, p.x, p.y, p.c);
                    end
                end
            end
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if (plot !== 1'b1) begin
                    failures++;
                    $display("FAIL done_without_plot got plot=%b want 1", plot);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({rom_addr, rom_sel, x, y, colour} !== '0) begin
            failures++;
            $display("FAIL reset_values got addr=%0d sel=%b x=%0d y=%0d c=%0d want all 0",
                     rom_addr, rom_sel, x, y, colour);
        end
        checks++;
        if ({plot, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes got plot=%b busy=%b done=%b want 000", plot, busy, done);
        end
    endtask

    task automatic test_title_sweep();
        int  bp, bd, k;
        bit  ok;
        logic b1, s1;
        showTitle = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL title_held_in_reset got busy=%b want 0", busy);
        end
        bp = nplot; bd = ndone;
        push_sweep(1'b0, 0, NPIX - 1);
        rst = 1'b0;
        k = 0; b1 = 1'b0; s1 = 1'b1;
        do begin
            @(negedge clk); #1;
            k++;
            if (k == 1) begin b1 = busy; s1 = rom_sel; end
        end while (plot !== 1'b1 && k < 10);
        checks++;
        if (k != 3) begin
            failures++;
            $display("FAIL first_plot_latency got %0d want 3", k);
        end
        checks++;
        if (b1 !== 1'b1 || s1 !== 1'b0) begin
            failures++;
            $display("FAIL first_fetch got busy=%b sel=%b want busy=1 sel=0", b1, s1);
        end
        wait_done(NPIX + 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL title_done_timeout got none want done");
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (nplot - bp != NPIX || ndone - bd != 1 || exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL title_totals got plots=%0d dones=%0d left=%0d busy=%b want %0d 1 0 0",
                     nplot - bp, ndone - bd, exp_q.size(), busy, NPIX);
        end
    endtask

    task automatic test_simultaneous();
        int bp, bd;
        bit ok;
        idle_flags();
        bp = nplot; bd = ndone;
        push_sweep(1'b1, 0, NPIX - 1);
        showTitle = 1'b1;
        showGameOver = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (rom_sel !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL simul_sel got sel=%b busy=%b want 1 1", rom_sel, busy);
        end
        wait_done(NPIX + 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL simul_done_timeout got none want done");
        end
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (nplot - bp != NPIX || ndone - bd != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL simul_totals got plots=%0d dones=%0d left=%0d want %0d 1 0",
                     nplot - bp, ndone - bd, exp_q.size(), NPIX);
        end
    endtask

    task automatic test_abort();
        int bp, bd, k;
        bit ok;
        idle_flags();
        bp = nplot; bd = ndone;
        // Pixels 0..4999 plotted, 5000 in the plot register, 5001 in flight at the abort
        push_sweep(1'b0, 0, 5001);
        showTitle = 1'b1;
        k = 0;
        while (nplot - bp < 5000 && k < 6000) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (nplot - bp != 5000) begin
            failures++;
            $display("FAIL abort_reach_5000 got %0d want 5000", nplot - bp);
        end
        push_sweep(1'b1, 0, NPIX - 1);
        showGameOver = 1'b1;
        wait_done(NPIX + 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL abort_done_timeout got none want done");
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (nplot - bp != 5002 + NPIX || ndone - bd != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_totals got plots=%0d dones=%0d left=%0d want %0d 1 0",
                     nplot - bp, ndone - bd, exp_q.size(), 5002 + NPIX);
        end
    endtask

    task automatic test_hold_no_redraw();
        int bp, nb;
        bp = nplot; nb = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (busy !== 1'b0) nb++;
        end
        checks++;
        if (nplot - bp != 0 || nb != 0) begin
            failures++;
            $display("FAIL hold_redraw got plots=%0d busy_cycles=%0d want 0 0", nplot - bp, nb);
        end
    endtask

    task automatic test_rst_mid_sweep();
        int bp, k;
        idle_flags();
        bp = nplot;
        push_sweep(1'b0, 0, 99);
        showTitle = 1'b1;
        k = 0;
        while (nplot - bp < 100 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({plot, busy, done} !== 3'b000 || x !== 8'd0 || y !== 7'd0) begin
            failures++;
            $display("FAIL rst_mid got plot=%b busy=%b done=%b x=%0d y=%0d want 0",
                     plot, busy, done, x, y);
        end
        checks++;
        if (nplot - bp != 100 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rst_mid_count got plots=%0d left=%0d want 100 0", nplot - bp, exp_q.size());
        end
        @(negedge clk); #1;
        bp = nplot;
        push_sweep(1'b0, 0, 299);
        rst = 1'b0;
        k = 0;
        while (nplot - bp < 300 && k < 400) begin
            @(negedge clk); #1;
            k++;
        end
        rst = 1'b1;
        checks++;
        if (nplot - bp != 300 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rst_resweep got plots=%0d left=%0d want 300 0", nplot - bp, exp_q.size());
        end
        @(negedge clk); #1;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_title_sweep();
        test_simultaneous();
        test_abort();
        test_hold_no_redraw();
        test_rst_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
